// File: rtl/translation_pkg.sv
// ============================================================================
// Module      : translation_pkg
// Description : Shared address-translation types for the MIPS core: CP0
//               register layouts, TLB entry format, lookup response, management
//               op encoding and the CP0-to-entry conversion helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package translation_pkg;

   localparam int TLB_ENTRIES = 16;
   localparam int TLB_NCH     = 2;
   localparam int TLB_ADDR_W  = 6;        // wide enough for the largest table (64)

   localparam logic [2:0] KSEG0_FLAG = 3'd3;   // cached, unmapped
   localparam logic [2:0] KSEG1_FLAG = 3'd2;   // uncached, unmapped

   typedef enum logic [1:0] {
      TLBP  = 2'd0,
      TLBR  = 2'd1,
      TLBWI = 2'd2,
      TLBWR = 2'd3
   } tlb_op_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } tlb_fsm_e;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [4:0]  zero;
      logic [7:0]  asid;
   } cp0_entryhi_t;

   typedef struct packed {
      logic [5:0]  zero;
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
      logic        g;
   } cp0_entrylo_t;

   typedef logic [31:0] cp0_index_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0]           paddr;
      logic                  hit;
      logic                  dirty;
      logic                  valid;
      logic [TLB_ADDR_W-1:0] tlb_addr;
      logic [2:0]            cache_flag;
   } tlblut_resp_t;

   typedef struct packed {
      cp0_entryhi_t entryhi;
      cp0_entrylo_t entrylo0;
      cp0_entrylo_t entrylo1;
      cp0_index_t   index;
   } tu_op_req_t;

   // A page pair is global only when both halves say so.
   function automatic tlb_entry_t entry_from_cp0(input cp0_entryhi_t hi,
                                                 input cp0_entrylo_t lo0,
                                                 input cp0_entrylo_t lo1);
      tlb_entry_t e;
      e.vpn2 = hi.vpn2;
      e.asid = hi.asid;
      e.g    = lo0.g & lo1.g;
      e.pfn0 = lo0.pfn;
      e.c0   = lo0.c;
      e.d0   = lo0.d;
      e.v0   = lo0.v;
      e.pfn1 = lo1.pfn;
      e.c1   = lo1.c;
      e.d1   = lo1.d;
      e.v1   = lo1.v;
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_match.sv
// ============================================================================
// Module      : tlb_match
// Description : Combinational associative match of one vpn2/asid against the
//               whole TLB. Returns the hit vector, the lowest matching index
//               and, when TLB_MULTIHIT_EN is defined, a multi-match flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_match
   import translation_pkg::*;
#(
   parameter int ENTRIES = TLB_ENTRIES,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic [18:0]                vpn2,
   input  logic [7:0]                 asid,
   input  tlb_entry_t [ENTRIES-1:0]   tlb_table,
   output logic [ENTRIES-1:0]         hit_vec,
   output logic                       hit,
   output logic [IDX_W-1:0]           idx,
   output logic                       multihit
);

   // Per-entry compare: VPN2 equal and either global or same address space.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hit_vec[i] = (tlb_table[i].vpn2 == vpn2) &&
                      (tlb_table[i].g || (tlb_table[i].asid == asid));
      end
   end

   // Priority encode so the lowest matching index wins.
   always_comb begin
      idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) idx = IDX_W'(i);
      end
   end

   assign hit = |hit_vec;

`ifdef TLB_MULTIHIT_EN
   // Clearing the lowest set bit leaves something only if two or more matched.
   assign multihit = |(hit_vec & (hit_vec - ENTRIES'(1)));
`else
   assign multihit = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/tlb_mmu.sv
// ============================================================================
// Module      : tlb_mmu
// Description : Joint TLB with NCH pipelined lookup channels (ch0 ifetch,
//               ch1 data), CP0 tlbp/tlbr/tlbwi/tlbwr execution through a
//               two-state management FSM, and the CP0 Random register.
//               Optional feature macro: TLB_MULTIHIT_EN (multi-match report).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_mmu
   import translation_pkg::*;
#(
   parameter int ENTRIES = TLB_ENTRIES,
   parameter int NCH     = TLB_NCH,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NCH-1:0]            lk_req,
   input  logic [NCH-1:0][31:0]      lk_vaddr,
   input  logic [NCH-1:0]            lk_store,
   input  logic [7:0]                cur_asid,
   output tlblut_resp_t [NCH-1:0]    lk_resp,
   output logic [NCH-1:0]            lk_refill,
   output logic [NCH-1:0]            lk_invalid,
   output logic [NCH-1:0]            lk_modified,
   output logic [NCH-1:0]            lk_multihit,
   input  logic                      op_valid,
   output logic                      op_ready,
   input  tlb_op_e                   op_code,
   input  cp0_entryhi_t              op_entryhi,
   input  cp0_entrylo_t              op_entrylo0,
   input  cp0_entrylo_t              op_entrylo1,
   input  cp0_index_t                op_index,
   output logic                      op_done,
   output tu_op_req_t                op_rd,
   input  logic [IDX_W-1:0]          wired,
   input  logic                      wired_we,
   output logic [IDX_W-1:0]          random
);

   localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(ENTRIES - 1);

   tlb_entry_t [ENTRIES-1:0] r_tlb;
   tlb_fsm_e                 r_state;
   tlb_fsm_e                 w_state_nxt;
   logic                     w_accept;
   logic [IDX_W-1:0]         r_random;
   tu_op_req_t               r_op_rd;

   tlblut_resp_t [NCH-1:0]   w_resp;
   logic [NCH-1:0]           w_refill;
   logic [NCH-1:0]           w_invalid;
   logic [NCH-1:0]           w_modified;
   logic [NCH-1:0]           w_multihit;

   tlblut_resp_t [NCH-1:0]   r_resp;
   logic [NCH-1:0]           r_refill;
   logic [NCH-1:0]           r_invalid;
   logic [NCH-1:0]           r_modified;
   logic [NCH-1:0]           r_multihit;

   // ---------------------------------------------------------------------
   // Lookup channels
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [ENTRIES-1:0] w_hit_vec;
      logic               w_hit;
      logic [IDX_W-1:0]   w_idx;
      logic               w_mh;
      tlb_entry_t         w_ent;
      logic               w_mapped;
      logic               w_pg_v;
      logic               w_pg_d;
      tlblut_resp_t       w_r;
      logic               w_unused_ch;

      tlb_match #(
         .ENTRIES (ENTRIES),
         .IDX_W   (IDX_W)
      ) u_match (
         .vpn2      (lk_vaddr[g][31:13]),
         .asid      (cur_asid),
         .tlb_table (r_tlb),
         .hit_vec   (w_hit_vec),
         .hit       (w_hit),
         .idx       (w_idx),
         .multihit  (w_mh)
      );

      assign w_ent    = r_tlb[w_idx];
      assign w_mapped = (lk_vaddr[g][31:30] != 2'b10);

      // Build the response: kseg0/kseg1 bypass, otherwise odd/even page select.
      always_comb begin
         w_r    = '0;
         w_pg_v = 1'b0;
         w_pg_d = 1'b0;
         if (!w_mapped) begin
            w_r.paddr      = {3'b000, lk_vaddr[g][28:0]};
            w_r.hit        = 1'b1;
            w_r.valid      = 1'b1;
            w_r.dirty      = 1'b1;
            w_r.cache_flag = lk_vaddr[g][29] ? KSEG1_FLAG : KSEG0_FLAG;
         end else begin
            if (lk_vaddr[g][12]) begin
               w_r.paddr      = {w_ent.pfn1, lk_vaddr[g][11:0]};
               w_r.cache_flag = w_ent.c1;
               w_pg_v         = w_ent.v1;
               w_pg_d         = w_ent.d1;
            end else begin
               w_r.paddr      = {w_ent.pfn0, lk_vaddr[g][11:0]};
               w_r.cache_flag = w_ent.c0;
               w_pg_v         = w_ent.v0;
               w_pg_d         = w_ent.d0;
            end
            w_r.hit      = w_hit;
            w_r.valid    = w_hit & w_pg_v;
            w_r.dirty    = w_hit & w_pg_d;
            w_r.tlb_addr = TLB_ADDR_W'(w_idx);
         end
      end

      assign w_resp[g]     = w_r;
      assign w_refill[g]   = w_mapped & ~w_hit;
      assign w_invalid[g]  = w_mapped & w_hit & ~w_pg_v;
      assign w_modified[g] = w_mapped & w_hit & w_pg_v & lk_store[g] & ~w_pg_d;
      assign w_multihit[g] = w_mapped & w_mh;
      assign w_unused_ch   = ^w_hit_vec;
   end

   // Register responses; data holds when idle, flags are qualified by request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_resp     <= '0;
         r_refill   <= '0;
         r_invalid  <= '0;
         r_modified <= '0;
         r_multihit <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (lk_req[c]) r_resp[c] <= w_resp[c];
         end
         r_refill   <= lk_req & w_refill;
         r_invalid  <= lk_req & w_invalid;
         r_modified <= lk_req & w_modified;
`ifdef TLB_MULTIHIT_EN
         r_multihit <= lk_req & w_multihit;
`else
         r_multihit <= '0;
`endif
      end
   end

   assign lk_resp     = r_resp;
   assign lk_refill   = r_refill;
   assign lk_invalid  = r_invalid;
   assign lk_modified = r_modified;
   assign lk_multihit = r_multihit;

   // ---------------------------------------------------------------------
   // Management port
   // ---------------------------------------------------------------------
   logic [ENTRIES-1:0] w_p_hit_vec;
   logic               w_p_hit;
   logic [IDX_W-1:0]   w_p_idx;
   logic               w_p_mh;
   tlb_entry_t         w_new_entry;
   tlb_entry_t         w_rd_ent;
   cp0_entryhi_t       w_rd_hi;
   cp0_entrylo_t       w_rd_lo0;
   cp0_entrylo_t       w_rd_lo1;

   tlb_match #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_probe (
      .vpn2      (op_entryhi.vpn2),
      .asid      (op_entryhi.asid),
      .tlb_table (r_tlb),
      .hit_vec   (w_p_hit_vec),
      .hit       (w_p_hit),
      .idx       (w_p_idx),
      .multihit  (w_p_mh)
   );

   assign w_new_entry = entry_from_cp0(op_entryhi, op_entrylo0, op_entrylo1);
   assign w_rd_ent    = r_tlb[op_index[IDX_W-1:0]];

   // Unpack a table entry into CP0 register images for tlbr.
   always_comb begin
      w_rd_hi       = '0;
      w_rd_lo0      = '0;
      w_rd_lo1      = '0;
      w_rd_hi.vpn2  = w_rd_ent.vpn2;
      w_rd_hi.asid  = w_rd_ent.asid;
      w_rd_lo0.pfn  = w_rd_ent.pfn0;
      w_rd_lo0.c    = w_rd_ent.c0;
      w_rd_lo0.d    = w_rd_ent.d0;
      w_rd_lo0.v    = w_rd_ent.v0;
      w_rd_lo0.g    = w_rd_ent.g;
      w_rd_lo1.pfn  = w_rd_ent.pfn1;
      w_rd_lo1.c    = w_rd_ent.c1;
      w_rd_lo1.d    = w_rd_ent.d1;
      w_rd_lo1.v    = w_rd_ent.v1;
      w_rd_lo1.g    = w_rd_ent.g;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM next state and handshake outputs; BUSY lasts exactly one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      op_ready    = 1'b0;
      op_done     = 1'b0;
      case (r_state)
         IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            op_done     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Execute the accepted op at the accept edge: table writes or op_rd capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tlb   <= '0;
         r_op_rd <= '0;
      end else if (w_accept) begin
         case (op_code)
            TLBP:  r_op_rd.index <= w_p_hit ? {1'b0, 31'(w_p_idx)} : 32'h8000_0000;
            TLBR: begin
               r_op_rd.entryhi  <= w_rd_hi;
               r_op_rd.entrylo0 <= w_rd_lo0;
               r_op_rd.entrylo1 <= w_rd_lo1;
            end
            TLBWI: r_tlb[op_index[IDX_W-1:0]] <= w_new_entry;
            TLBWR: r_tlb[r_random]            <= w_new_entry;
            default: ;
         endcase
      end
   end

   assign op_rd = r_op_rd;

   // Random: free-running down-counter that wraps to the top at Wired.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                  r_random <= C_IDX_MAX;
      else if (wired_we)            r_random <= C_IDX_MAX;
      else if (wired >= C_IDX_MAX)  r_random <= C_IDX_MAX;
      else if (r_random == wired)   r_random <= C_IDX_MAX;
      else                          r_random <= r_random - IDX_W'(1);
   end

   assign random = r_random;

   logic w_unused;
   assign w_unused = ^{w_p_hit_vec, w_p_mh, w_multihit, op_index,
                       op_entryhi.zero, op_entrylo0.zero, op_entrylo1.zero};

endmodule

`default_nettype wire

// File: doc/tlb_mmu.md
# tlb_mmu

Parametrised joint TLB for the MIPS core. It serves `NCH` independent address-translation lookup channels: channel 0 is instruction fetch, channel 1 is data, and extra channels are spare. Each lookup returns a registered result one cycle after the request. The block also executes the CP0 TLB instructions `tlbp`, `tlbr`, `tlbwi` and `tlbwr`, and maintains the Random register. It sits between the fetch/memory stages and the cache bus, and CP0 drives its management port.

## Interface
- `ENTRIES`, default `TLB_ENTRIES` (16): number of entries; a power of two, 4..64.
- `NCH`, default 2: number of lookup channels, 1..4.
- `IDX_W`, default `$clog2(ENTRIES)`: index width.

Ports:
- `clk`  in  1  core clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `lk_req`  in  `NCH`  per-channel lookup valid.
- `lk_vaddr`  in  `NCH`×32  virtual address.
- `lk_store`  in  `NCH`  lookup is a store (qualifies Modified).
- `cur_asid`  in  8  EntryHi.ASID currently in CP0.
- `lk_resp`  out  `NCH`×`tlblut_resp_t`  paddr/hit/dirty/valid/tlb_addr/cache_flag.
- `lk_refill`, `lk_invalid`, `lk_modified`  out  `NCH` each  exception flags, registered.
- `lk_multihit`  out  `NCH`  more than one entry matched (see Configuration).
- `op_valid`  in  1  management op request.
- `op_ready`  out  1  management port idle.
- `op_code`  in  2  `tlb_op_e`: 0 = `TLBP`, 1 = `TLBR`, 2 = `TLBWI`, 3 = `TLBWR`.
- `op_entryhi`, `op_entrylo0`, `op_entrylo1`, `op_index`  in  CP0 types  operands.
- `op_done`  out  1  one-cycle completion pulse.
- `op_rd`  out  `tu_op_req_t`  tlbr data, or tlbp index (`index[31]` = P).
- `wired`  in  `IDX_W`  CP0 Wired.
- `wired_we`  in  1  CP0 write to Wired.
- `random`  out  `IDX_W`  CP0 Random.

## Operation
- **Unmapped lookups:** `vaddr[31:30]==2'b10` (kseg0/kseg1) bypasses the TLB.
  - `paddr = {3'b0, vaddr[28:0]}`.
  - `hit = valid = dirty = 1`, no exceptions.
  - `cache_flag` is 3 for kseg0 and 2 for kseg1.
- **Match rule:** an entry matches when `vpn2 == vaddr[31:13]` and (`G` or `asid == cur_asid`). `vaddr[12]` selects the odd page (`pfn1/C1/V1/D1`) or the even page.
- **Mapped lookup flags:**
  - No match: `lk_refill = 1`.
  - Match with V = 0: `lk_invalid = 1`.
  - Match, V = 1, store, D = 0: `lk_modified = 1`.
  - `paddr = {pfn, vaddr[11:0]}`.
- **Multiple matches:** the lowest index wins.
- **Flag qualification:** with `lk_req = 0`, the response registers keep their previous values and all flags are driven 0.
- **Management FSM:** two states, `IDLE` and `BUSY`. `op_ready = (state == IDLE)`.
  - **Accept:** `op_valid && op_ready` moves the FSM to `BUSY` for exactly 1 cycle. `op_done` pulses in that cycle, then the FSM returns to `IDLE`.
  - **TLBWI:** writes entry `op_index[IDX_W-1:0]` at the accept edge.
  - **TLBWR:** writes entry `random` at the accept edge.
  - **Write field mapping:** `vpn2`/`asid` come from EntryHi. `G = lo0.G & lo1.G`. PFN/C/D/V come from each EntryLo.
  - **TLBP:** matches `op_entryhi` against all entries using EntryHi.ASID. On a hit, `op_rd.index = {1'b0, idx}`. On a miss, it is `32'h8000_0000`.
  - **TLBR:** `op_rd` returns entry `op_index`. EntryLo.G is replicated from the entry's `G`.
  - `op_rd` holds its value until the next `op_done`.
- **Random counter:** decrements every cycle.
  - When `random == wired`, the next value is `ENTRIES-1`.
  - `wired_we` forces `ENTRIES-1` on the next edge and has priority over the decrement.
  - A `wired` value ≥ `ENTRIES-1` holds Random at `ENTRIES-1`.

## Timing
- **Lookup latency:** 1 cycle. A request sampled at edge t produces its response after edge t, valid throughout cycle t+1. Lookups are fully pipelined, one per channel per cycle.
- **Write vs. lookup in the same cycle:** a lookup sampled at the same edge as a write sees the old table contents. It sees the new contents from the next cycle.
- **TLBP after write:** a tlbp accepted in the cycle after a tlbwi sees the new entry.
- **Op throughput:** at most one op per 2 cycles; `op_valid` while `BUSY` is ignored (not queued).
- **Reset values:**
  - All entries are zero (V = 0, G = 0).
  - `random = ENTRIES-1`.
  - `state = IDLE`.
  - `lk_resp`, `op_rd`, all flags and `op_done` are 0.
  - `op_ready = 1` one cycle after deassertion.
- **Reset mid-operation:** an in-flight op is dropped with no `op_done`, and the table returns to its reset contents.

## Configuration
- `TLB_MULTIHIT_EN` defined:
  - A mapped lookup or tlbp matching 2+ entries sets `lk_multihit` for that channel, registered with the response.
  - TLBP on a multihit returns the lowest index with P = 0.
- `TLB_MULTIHIT_EN` undefined: `lk_multihit` is tied to 0 and the multi-match detection logic is absent. Lowest-index-wins behaviour is unchanged.

## Structure
- **Shared package (`translation_pkg`):** add
  - `tlb_op_e`;
  - `TLB_NCH`;
  - the `KSEG0_FLAG`/`KSEG1_FLAG` constants;
  - a function `entry_from_cp0` that builds a `tlb_entry_t` from EntryHi/EntryLo0/EntryLo1.
- **Sub-module `tlb_match`:** combinational; takes vpn2, asid and the table, and returns a hit vector, the first-hit index and a multihit flag. It is instantiated `NCH` times for lookups plus once for tlbp.
- **Top level:** holds the table, the FSM, the Random counter and the output registers.

## Test plan
1. Reset, then lookup `vaddr=32'hBFC0_0000` on ch0 → next cycle `paddr=32'h1FC0_0000`, `hit=1`, `cache_flag=2`, `random=15`.
2. tlbwi index 3: `vpn2=19'h00400`, `asid=8'h05`, `G=0`, `pfn1=20'h00123`, `V1=1`, `D1=0`. Then a store lookup on ch1 at `32'h0080_1ABC` with `cur_asid=5` → `paddr=32'h0012_3ABC`, `lk_modified=1`, `tlb_addr=3`.
3. Same lookup with `cur_asid=6` → `lk_refill=1`. Then tlbp with `asid=5` → `op_done`, `op_rd.index=32'h3`. A tlbp for a missing vpn2 → `32'h8000_0000`.
4. Set `wired=4` with `wired_we`, then run 13 cycles → `random` sequence 15,14,…,4,15. Issue tlbwr in cycle k → tlbr at the same index returns the written entry.
5. Lookup issued in the same cycle as a tlbwi to its matching entry → refill (old contents). The same lookup one cycle later → hit.
6. With `TLB_MULTIHIT_EN`: write identical vpn2/G=1 to entries 2 and 7, then lookup → `lk_multihit=1`, `tlb_addr=2`. Without the macro → `lk_multihit=0`, `tlb_addr=2`.
